mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
- Request sequencer directly upstream of the 256x32 banked word memory (4 banks x 64 words, bank chosen by address[7:6]).
- Accepts single or burst read/write requests over a valid/ready interface and streams write data in.
- Drives the memory's address, write-enable and data-in pins from registers.
- Captures memory read data and returns it as a valid-qualified stream with a last-beat flag.

Parameters:
- LEN_W, 4, width of burst-length field; beats per request = req_len+1 (1..16 at default).
- ADDR_W, 8, memory word-address width; fixed to the memory's 8-bit address.
- DATA_W, 32, data width; fixed to the memory's 32-bit word.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept request (combinational: state==IDLE)
- req_write  input  1  1=write burst, 0=read burst
- req_addr  input  ADDR_W  start word address
- req_len  input  LEN_W  beats minus one
- wdata_valid  input  1  write beat present
- wdata_ready  output  1  write beat accepted (combinational: state==WBURST)
- wdata  input  DATA_W  write beat data
- rdata_valid  output  1  read beat valid; no backpressure
- rdata  output  DATA_W  read beat data
- rdata_last  output  1  final beat of read burst
- busy  output  1  state!=IDLE or read pipeline non-empty
- mem_addr  output  ADDR_W  memory Address
- mem_write  output  1  memory Write
- mem_in  output  DATA_W  memory In
- mem_dout  input  DATA_W  memory Dout; valid one cycle after mem_addr presented with mem_write=0

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; mem_addr, mem_in, rdata, beat counter and address counter = 0.
  - mem_write, rdata_valid, rdata_last, busy = 0.
  - Any in-flight burst is abandoned.
  - Memory writes already performed remain.
- States: IDLE, WBURST, RBURST, RDRAIN.
- IDLE:
  - req_ready=1 only when the read pipeline is empty.
  - On req_valid&&req_ready: load addr_cnt=req_addr, beat_cnt=req_len; go to WBURST if req_write, else RBURST.
  - mem_write=0 every cycle.
- WBURST:
  - Each wdata_valid&&wdata_ready edge registers mem_addr=addr_cnt, mem_in=wdata, mem_write=1 for exactly the next cycle.
  - Then addr_cnt+=1 and beat_cnt-=1.
  - Cycles without a handshake register mem_write=0.
  - The handshake on beat_cnt==0 returns to IDLE; its write is still performed the following cycle.
- RBURST:
  - Every cycle registers mem_addr=addr_cnt, mem_write=0.
  - Pushes a token {valid=1, last=(beat_cnt==0)} into a 2-stage shift register; addr_cnt+=1, beat_cnt-=1.
  - On beat_cnt==0 go to RDRAIN.
- RDRAIN:
  - Tokens shift out.
  - When stage 2 is clear (pipeline empty), go to IDLE.
- Read return:
  - rdata<=mem_dout, rdata_valid<=stage2.valid, rdata_last<=stage2.last.
  - Request handshake at edge E0 gives beat0 rdata_valid high after edge E3.
  - Subsequent beats are back-to-back, one per cycle.
- Address arithmetic: modulo 2^ADDR_W; 8'hFF+1 wraps to 8'h00, crossing banks transparently.
- Simultaneous events:
  - req_valid while busy is ignored.
  - wdata_valid outside WBURST is ignored (wdata_ready=0).
  - No read/write overlap is possible.
- busy is registered-equivalent: high from the cycle after acceptance until the cycle after the last rdata_valid or last mem_write.

Optional Feature:
- Macro: MEM_BURST_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_wr_beats[15:0] and stat_rd_beats[15:0], plus input stat_clr.
  - Counters increment per mem_write=1 cycle and per rdata_valid cycle, saturating at 16'hFFFF.
  - stat_clr=1 zeroes both counters the next edge and wins over a simultaneous increment.
  - Counters reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_burst_pkg holds:
  - state enum {IDLE, WBURST, RBURST, RDRAIN};
  - constants ADDR_W=8, DATA_W=32, RD_LAT=2;
  - a rd_token_t struct {valid, last}.
- One sub-module: mem_burst_rdpipe, the RD_LAT-deep token shift register plus rdata capture register; it exposes an empty flag.

Test Plan:
- Single write then read:
  - write addr 8'h05, len 0, data 32'hDEADBEEF gives one mem_write pulse with mem_addr=05.
  - Read addr 05, len 0 gives rdata=DEADBEEF with rdata_last=1, 3 cycles after acceptance.
- Burst write with stalls: addr 8'h3E, len 3, wdata_valid gapped every other cycle gives 4 mem_write pulses at addresses 3E, 3F, 40, 41 (bank crossing), with none during gaps.
- Wrap: write len 2 at addr 8'hFE gives addresses FE, FF, 00; a read-back of 3 beats returns matching data in order, with rdata_last on beat 3 only.
- Busy rejection: req_valid held through a 16-beat read gives req_ready=0 until the pipeline is empty; exactly one request is accepted.
- Mid-burst reset: rst_n low during beat 2 of an 8-beat write:
  - outputs go to 0 immediately and state is IDLE;
  - beats 0–1 are present in memory, later addresses unchanged.
- Stats (macro defined): 5 write beats plus 7 read beats gives stat_wr_beats=5, stat_rd_beats=7; stat_clr gives 0 the next cycle.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// rtl/mem_burst_pkg.sv - shared types and constants for the memory burst sequencer
// Contents:
//   ADDR_W, DATA_W  geometry of the 256x32 banked word memory
//   RD_LAT          depth of the read token pipeline (address register + memory read)
//   state_t         controller state encoding (IDLE, WBURST, RBURST, RDRAIN)
//   rd_token_t      {valid, last} marker travelling alongside each read beat
package mem_burst_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t WBURST = 2'd1;
  localparam state_t RBURST = 2'd2;
  localparam state_t RDRAIN = 2'd3;

  typedef struct packed {
    logic valid;
    logic last;
  } rd_token_t;

endpackage

// File: rtl/mem_burst_rdpipe.sv
// rtl/mem_burst_rdpipe.sv - read token delay line and read data capture register
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push_tok      token entering stage 1 this cycle ({0,0} when no read issued)
//   mem_dout      memory read data, valid one cycle after the address register
//   rdata         captured read data
//   rdata_valid   token valid leaving the last stage, aligned with rdata
//   rdata_last    token last flag, aligned with rdata
//   empty         no valid token anywhere in the delay line
module mem_burst_rdpipe
  import mem_burst_pkg::*;
#(
  parameter int DEPTH = RD_LAT,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  rd_token_t     push_tok,
  input  logic [DW-1:0] mem_dout,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          rdata_last,
  output logic          empty
);

  // stage[0] matches the cycle mem_addr is registered, stage[DEPTH-1]
  // matches the cycle mem_dout carries that beat's data.
  rd_token_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= push_tok;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
    end else begin
      rdata       <= mem_dout;
      rdata_valid <= stage[DEPTH-1].valid;
      rdata_last  <= stage[DEPTH-1].last;
    end
  end

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (stage[i].valid) begin
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - single/burst read-write sequencer in front of the 256x32 banked memory
// Optional build macro: MEM_BURST_CTRL_STATS_EN adds stat_clr, stat_wr_beats, stat_rd_beats.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only when idle and read pipe empty)
//   req_write, req_addr, req_len    direction, start word address, beats minus one
//   wdata_valid/wdata_ready, wdata  write beat stream (ready only during a write burst)
//   rdata_valid, rdata, rdata_last  read beat stream, no backpressure
//   busy                            burst in progress or beats still in flight
//   mem_addr, mem_write, mem_in     registered memory pins
//   mem_dout                        memory read data
//   stat_clr, stat_wr_beats, stat_rd_beats  beat counters (macro builds only)
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int LEN_W  = 4,
  parameter int ADDR_W = mem_burst_pkg::ADDR_W,
  parameter int DATA_W = mem_burst_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_dout
`ifdef MEM_BURST_CTRL_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_wr_beats,
  output logic [15:0]       stat_rd_beats
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN_W-1:0]  beat_cnt;
  logic              pipe_empty;
  logic              last_beat;
  rd_token_t         push_tok;

  assign last_beat   = (beat_cnt == '0);
  assign req_ready   = (state == IDLE) && pipe_empty;
  assign wdata_ready = (state == WBURST);

  // The final write pulse and the final read beat both land after the
  // state has already returned to IDLE / left RBURST, so they keep busy up.
  assign busy = (state != IDLE) || !pipe_empty || mem_write || rdata_valid;

  always_comb begin
    push_tok       = '0;
    push_tok.valid = (state == RBURST);
    push_tok.last  = (state == RBURST) && last_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      beat_cnt  <= '0;
      mem_addr  <= '0;
      mem_in    <= '0;
      mem_write <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_cnt <= req_addr;
            beat_cnt <= req_len;
            state    <= req_write ? WBURST : RBURST;
          end
        end
        WBURST: begin
          if (wdata_valid) begin
            mem_addr  <= addr_cnt;
            mem_in    <= wdata;
            mem_write <= 1'b1;
            // Address wraps modulo 2^ADDR_W, crossing banks transparently.
            addr_cnt  <= addr_cnt + 1'b1;
            beat_cnt  <= beat_cnt - 1'b1;
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        RBURST: begin
          mem_addr <= addr_cnt;
          addr_cnt <= addr_cnt + 1'b1;
          beat_cnt <= beat_cnt - 1'b1;
          if (last_beat) begin
            state <= RDRAIN;
          end
        end
        RDRAIN: begin
          if (pipe_empty) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_burst_rdpipe #(
    .DEPTH(RD_LAT),
    .DW   (DATA_W)
  ) u_rdpipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_tok   (push_tok),
    .mem_dout   (mem_dout),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .rdata_last (rdata_last),
    .empty      (pipe_empty)
  );

`ifdef MEM_BURST_CTRL_STATS_EN
  // Clear has priority over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_beats <= '0;
      stat_rd_beats <= '0;
    end else if (stat_clr) begin
      stat_wr_beats <= '0;
      stat_rd_beats <= '0;
    end else begin
      if (mem_write && (stat_wr_beats != 16'hFFFF)) begin
        stat_wr_beats <= stat_wr_beats + 16'd1;
      end
      if (rdata_valid && (stat_rd_beats != 16'hFFFF)) begin
        stat_rd_beats <= stat_rd_beats + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - directed table-driven bench for mem_burst_ctrl with a 256x32 memory model
module tb_mem_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [3:0]  req_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_write;
  logic [31:0] mem_in;
  logic [31:0] mem_dout;
`ifdef MEM_BURST_CTRL_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_wr_beats;
  logic [15:0] stat_rd_beats;
`endif

  always #5 clk = ~clk;

  mem_burst_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .rdata_last (rdata_last),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .mem_in     (mem_in),
    .mem_dout   (mem_dout)
`ifdef MEM_BURST_CTRL_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_wr_beats(stat_wr_beats),
    .stat_rd_beats(stat_rd_beats)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: data for address A appears one cycle after A.
  logic [31:0] mem [256] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_in;
    mem_dout <= mem[mem_addr];
  end

  typedef struct {logic [7:0] a; logic [31:0] d;} wrec_t;
  typedef struct {logic [31:0] d; logic l; int c;} rrec_t;
  wrec_t wlog[$];
  rrec_t rlog[$];

  always @(negedge clk) begin
    if (rst_n && mem_write) wlog.push_back('{mem_addr, mem_in});
    if (rst_n && rdata_valid) rlog.push_back('{rdata, rdata_last, cyc});
  end

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [3:0]  len;
    bit          gap;
    logic [7:0]  a [8];
    logic [31:0] d [8];
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    int t;
    wlog.delete();
    rlog.delete();
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_len   = v.len;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_active", {31'd0, busy}, 32'd1);
    if (v.wr) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        wdata_valid = 1'b1;
        wdata = v.d[i];
        @(posedge clk);
        @(negedge clk);
        wdata_valid = 1'b0;
        if (v.gap) begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      repeat (2) @(negedge clk);
      chk("wr_pulse_count", wlog.size(), v.len + 1);
      for (int i = 0; i < wlog.size() && i <= int'(v.len); i++) begin
        chk("wr_addr", {24'd0, wlog[i].a}, {24'd0, v.a[i]});
        chk("wr_data", wlog[i].d, v.d[i]);
      end
    end else begin
      t = 0;
      while (rlog.size() < v.len + 1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      repeat (2) @(negedge clk);
      chk("rd_beat_count", rlog.size(), v.len + 1);
      for (int i = 0; i < rlog.size() && i <= int'(v.len); i++) begin
        chk("rd_data", rlog[i].d, v.d[i]);
        chk("rd_last", {31'd0, rlog[i].l}, (i == int'(v.len)) ? 32'd1 : 32'd0);
        if (i == 0) chk("rd_latency", rlog[0].c - acc, 32'd3);
      end
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_n;
    int n_last;
    vec_t sv;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_len = '0;
    wdata_valid = 1'b0;
    wdata = '0;
`ifdef MEM_BURST_CTRL_STATS_EN
    stat_clr = 1'b0;
`endif

    vecs[0] = '{wr: 1'b1, addr: 8'h05, len: 4'd0, gap: 1'b0,
                a: '{0: 8'h05, default: 8'h00}, d: '{0: 32'hDEADBEEF, default: 32'h0}};
    vecs[1] = '{wr: 1'b0, addr: 8'h05, len: 4'd0, gap: 1'b0,
                a: '{default: 8'h00}, d: '{0: 32'hDEADBEEF, default: 32'h0}};
    vecs[2] = '{wr: 1'b1, addr: 8'h3E, len: 4'd3, gap: 1'b1,
                a: '{8'h3E, 8'h3F, 8'h40, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00},
                d: '{32'h100, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[3] = '{wr: 1'b1, addr: 8'hFE, len: 4'd2, gap: 1'b0,
                a: '{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                d: '{32'hA0, 32'hA1, 32'hA2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[4] = '{wr: 1'b0, addr: 8'hFE, len: 4'd2, gap: 1'b0,
                a: '{default: 8'h00},
                d: '{32'hA0, 32'hA1, 32'hA2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[5] = '{wr: 1'b0, addr: 8'h3F, len: 4'd2, gap: 1'b0,
                a: '{default: 8'h00},
                d: '{32'h101, 32'h102, 32'h103, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};

    // Reset state
    #12;
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Request held through a 16-beat read: exactly one acceptance.
    rlog.delete();
    acc_n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h40;
    req_len   = 4'hF;
    for (int t = 0; t < 60; t++) begin
      #1;
      if (req_ready) acc_n++;
      if (rlog.size() >= 16) break;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_accepts", acc_n, 32'd1);
    chk("hold_beats", rlog.size(), 32'd16);
    n_last = 0;
    foreach (rlog[i]) if (rlog[i].l) n_last++;
    chk("hold_last_count", n_last, 32'd1);
    if (rlog.size() == 16) begin
      chk("hold_last_pos", {31'd0, rlog[15].l}, 32'd1);
      chk("hold_beat0", rlog[0].d, 32'h102);
      chk("hold_beat1", rlog[1].d, 32'h103);
      chk("hold_beat2", rlog[2].d, 32'h0);
    end
    chk("hold_ready_after", {31'd0, req_ready}, 32'd1);

    // Reset while beat 2 of an 8-beat write is in flight.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h80;
    req_len   = 4'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wdata_valid = 1'b1;
      wdata = 32'h5000 + i;
      @(posedge clk);
      if (i < 2) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("mrst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("mrst_mem_in", mem_in, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_idle", {31'd0, req_ready}, 32'd1);
    chk("mrst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
    @(negedge clk);
    wdata_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_mem80", mem[8'h80], 32'h5000);
    chk("mrst_mem81", mem[8'h81], 32'h5001);
    for (int i = 2; i < 8; i++) chk("mrst_mem_untouched", mem[8'h80 + i], 32'h0);

`ifdef MEM_BURST_CTRL_STATS_EN
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    sv = '{wr: 1'b1, addr: 8'h20, len: 4'd4, gap: 1'b0,
           a: '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h00, 8'h00, 8'h00},
           d: '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h0, 32'h0, 32'h0}};
    run_vec(sv);
    sv = '{wr: 1'b0, addr: 8'h20, len: 4'd6, gap: 1'b0,
           a: '{default: 8'h00},
           d: '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h0, 32'h0, 32'h0}};
    run_vec(sv);
    chk("stat_wr", {16'd0, stat_wr_beats}, 32'd5);
    chk("stat_rd", {16'd0, stat_rd_beats}, 32'd7);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("stat_wr_clr", {16'd0, stat_wr_beats}, 32'd0);
    chk("stat_rd_clr", {16'd0, stat_rd_beats}, 32'd0);
    stat_clr = 1'b0;
`else
    sv = vecs[0];
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
